// File: rtl/adc_capture_sequencer.sv
// Armed, triggered, frame-counted capture control for the ADC-to-AXIS path.
// Optional drain watchdog enabled by defining ADC_CAPTURE_TIMEOUT_EN.
module adc_capture_sequencer #(
  parameter int CNT_WIDTH       = 16,
  parameter int FRAME_CNT_WIDTH = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_arm,
  input  logic                       i_trigger,
  input  logic                       i_abort,
  input  logic [CNT_WIDTH-1:0]       i_frame_len,
  input  logic [FRAME_CNT_WIDTH-1:0] i_num_frames,
  input  logic                       i_fifo_full,
  input  logic                       i_axis_tvalid,
  input  logic                       i_axis_tready,
  output logic                       o_con_adcside,
  output logic                       o_con_axisside,
  output logic                       o_tlast,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_aborted,
  output logic                       o_cfg_err,
  output logic                       o_overflow,
  output logic [FRAME_CNT_WIDTH-1:0] o_frame_cnt,
  output logic                       o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_WIDTH-1:0]       len_q, len_n;
  logic [FRAME_CNT_WIDTH-1:0] num_q, num_n;
  logic [CNT_WIDTH-1:0]       wr_cnt, wr_cnt_n;
  logic [CNT_WIDTH-1:0]       rd_cnt, rd_cnt_n;
  logic [FRAME_CNT_WIDTH-1:0] wr_frm, wr_frm_n;
  logic [FRAME_CNT_WIDTH-1:0] frm_cnt_n;

  logic adc_n, axis_n, done_n, abort_n;
  logic cfg_err_n, ovf_n, to_n;

  logic wr, beat, wr_last, rd_last;
  logic finite, fin_wr, fin_beat, to_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign wr     = o_con_adcside & ~i_fifo_full;
  assign beat   = i_axis_tvalid & i_axis_tready
                & o_con_axisside;
  assign finite = (num_q != '0);

  assign wr_last = (wr_cnt == len_q - CNT_WIDTH'(1));
  assign rd_last = (rd_cnt == len_q - CNT_WIDTH'(1));

  assign fin_wr = wr & wr_last & finite
                & (wr_frm == num_q - FRAME_CNT_WIDTH'(1));
  assign fin_beat = beat & rd_last & finite
                  & (o_frame_cnt == num_q - FRAME_CNT_WIDTH'(1));

  assign o_busy  = (state != S_IDLE);
  assign o_tlast = o_busy & rd_last;

`ifdef ADC_CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;

  assign to_hit = (state == S_DRAIN) & ~beat
                & (to_cnt == TO_LAST);

  // count beat-free drain cycles; any beat restarts the window
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt <= '0;
    end else if (state != S_DRAIN || beat) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // next state, counter updates and registered output values
  always_comb begin
    state_n   = state;
    len_n     = len_q;
    num_n     = num_q;
    wr_cnt_n  = wr_cnt;
    rd_cnt_n  = rd_cnt;
    wr_frm_n  = wr_frm;
    frm_cnt_n = o_frame_cnt;
    adc_n     = o_con_adcside;
    axis_n    = o_con_axisside;
    ovf_n     = o_overflow;
    done_n    = 1'b0;
    abort_n   = 1'b0;
    cfg_err_n = 1'b0;
    to_n      = 1'b0;
    if (state != S_IDLE && i_abort) begin
      state_n = S_IDLE;
      adc_n   = 1'b0;
      axis_n  = 1'b0;
      abort_n = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_arm) begin
            if (i_frame_len != '0) begin
              state_n   = S_ARMED;
              len_n     = i_frame_len;
              num_n     = i_num_frames;
              wr_cnt_n  = '0;
              rd_cnt_n  = '0;
              wr_frm_n  = '0;
              frm_cnt_n = '0;
              ovf_n     = 1'b0;
            end else begin
              cfg_err_n = 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (i_trigger) begin
            state_n = S_CAPTURE;
            adc_n   = 1'b1;
            axis_n  = 1'b1;
          end
        end
        S_CAPTURE, S_DRAIN: begin
          if (o_con_adcside && i_fifo_full) begin
            ovf_n = 1'b1;
          end
          if (wr) begin
            if (wr_last) begin
              wr_cnt_n = '0;
              wr_frm_n = wr_frm + FRAME_CNT_WIDTH'(1);
            end else begin
              wr_cnt_n = wr_cnt + CNT_WIDTH'(1);
            end
          end
          if (beat) begin
            if (rd_last) begin
              rd_cnt_n  = '0;
              frm_cnt_n = o_frame_cnt + FRAME_CNT_WIDTH'(1);
            end else begin
              rd_cnt_n = rd_cnt + CNT_WIDTH'(1);
            end
          end
          if (fin_beat) begin
            state_n = S_DONE;
            adc_n   = 1'b0;
            axis_n  = 1'b0;
            done_n  = 1'b1;
          end else if (to_hit) begin
            state_n = S_IDLE;
            adc_n   = 1'b0;
            axis_n  = 1'b0;
            to_n    = 1'b1;
          end else if (fin_wr) begin
            state_n = S_DRAIN;
            adc_n   = 1'b0;
          end
        end
        S_DONE: begin
          state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
          adc_n   = 1'b0;
          axis_n  = 1'b0;
        end
      endcase
    end
  end

  // state, latched config, counters and registered outputs
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= S_IDLE;
      len_q          <= '0;
      num_q          <= '0;
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      wr_frm         <= '0;
      o_frame_cnt    <= '0;
      o_con_adcside  <= 1'b0;
      o_con_axisside <= 1'b0;
      o_overflow     <= 1'b0;
      o_done         <= 1'b0;
      o_aborted      <= 1'b0;
      o_cfg_err      <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      state          <= state_n;
      len_q          <= len_n;
      num_q          <= num_n;
      wr_cnt         <= wr_cnt_n;
      rd_cnt         <= rd_cnt_n;
      wr_frm         <= wr_frm_n;
      o_frame_cnt    <= frm_cnt_n;
      o_con_adcside  <= adc_n;
      o_con_axisside <= axis_n;
      o_overflow     <= ovf_n;
      o_done         <= done_n;
      o_aborted      <= abort_n;
      o_cfg_err      <= cfg_err_n;
      o_timeout      <= to_n;
    end
  end

endmodule
